// File: rtl/dm_arbiter_if.sv
// Request/response bundle for one data-memory master port.
// master: drives req/we/be/addr/wdata and receives rdata/ack.
// slave: the arbiter side of the same signals.
interface dm_arbiter_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, be, addr, wdata, input rdata, ack);
    modport slave  (input req, we, be, addr, wdata, output rdata, ack);
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter/sequencer for the word-wide DM; partial stores become read-modify-write.
// Latency: ack 2 cycles after the sampling edge (read/full/be=0 write), 3 cycles for partial writes.
// Backpressure: one request in flight; the loser holds req until its own ack; one IDLE cycle after each DONE.
// Ports: clk, reset (async, active-high); m0/m1 master ports (dm_arbiter_if.slave);
//        dm_memwrite/dm_addr/dm_din to DM, dm_dout combinational read data from DM.
module dm_arbiter (
    input  logic          clk,
    input  logic          reset,
    dm_arbiter_if.slave   m0,
    dm_arbiter_if.slave   m1,
    output logic          dm_memwrite,
    output logic [31:0]   dm_addr,
    output logic [31:0]   dm_din,
    input  logic [31:0]   dm_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, DONE} state_t;

    state_t      state, state_nxt;
    logic        gnt;
    logic        last_grant;
    logic        l_we;
    logic [3:0]  l_be;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [31:0] merge_q;
    logic [31:0] merged;
    logic [31:0] rdata0, rdata1;
    logic        win;
    logic        rd_upd;
    logic [31:0] rd_val;
    logic        ack0, ack1;
    logic [31:0] word_addr;

    // On a tie the master not granted last time wins; a lone requester always wins.
    assign win = (m0.req && m1.req) ? ~last_grant : m1.req;

    // Byte-lane merge of latched write data over the word read in ACCESS.
    always_comb begin
        merged = merge_q;
        for (int i = 0; i < 4; i++) begin
            if (l_be[i]) merged[8*i +: 8] = l_wdata[8*i +: 8];
        end
    end

    // DM is word-indexed: the byte offset is masked off.
    assign word_addr = l_addr & 32'hFFFF_FFFC;

    always_comb begin
        state_nxt   = state;
        dm_memwrite = 1'b0;
        dm_addr     = 32'h0;
        dm_din      = 32'h0;
        rd_upd      = 1'b0;
        rd_val      = 32'h0;
        ack0        = 1'b0;
        ack1        = 1'b0;
        case (state)
            IDLE: begin
                if (m0.req || m1.req) state_nxt = ACCESS;
            end
            ACCESS: begin
                dm_addr = word_addr;
                if (!l_we || (l_be == 4'h0)) begin
                    rd_upd    = 1'b1;
                    rd_val    = dm_dout;
                    state_nxt = DONE;
                end else if (l_be == 4'hF) begin
                    dm_memwrite = 1'b1;
                    dm_din      = l_wdata;
                    rd_upd      = 1'b1;
                    rd_val      = l_wdata;
                    state_nxt   = DONE;
                end else begin
                    state_nxt = MERGE;
                end
            end
            MERGE: begin
                dm_addr     = word_addr;
                dm_memwrite = 1'b1;
                dm_din      = merged;
                rd_upd      = 1'b1;
                rd_val      = merged;
                state_nxt   = DONE;
            end
            DONE: begin
                ack0      = ~gnt;
                ack1      = gnt;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            l_we       <= 1'b0;
            l_be       <= 4'h0;
            l_addr     <= 32'h0;
            l_wdata    <= 32'h0;
            merge_q    <= 32'h0;
            rdata0     <= 32'h0;
            rdata1     <= 32'h0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (m0.req || m1.req)) begin
                gnt        <= win;
                last_grant <= win;
                l_we       <= win ? m1.we    : m0.we;
                l_be       <= win ? m1.be    : m0.be;
                l_addr     <= win ? m1.addr  : m0.addr;
                l_wdata    <= win ? m1.wdata : m0.wdata;
            end
            if (state == ACCESS) merge_q <= dm_dout;
            if (rd_upd) begin
                if (gnt) rdata1 <= rd_val;
                else     rdata0 <= rd_val;
            end
        end
    end

    assign m0.rdata = rdata0;
    assign m1.rdata = rdata1;
    assign m0.ack   = ack0;
    assign m1.ack   = ack1;

endmodule
